// File: rtl/booth_r8_seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential radix-8 Booth multiplier:
//   - mult_state_t : controller states
//   - ENC_*        : bit positions inside the 5-bit Booth digit encoding
//   - ndig()       : number of radix-8 Booth digits for an n-bit multiplier
// -----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECOMP = 2'd1,
        ACCUM   = 2'd2,
        DONE    = 2'd3
    } mult_state_t;

    localparam int ENC_NEG = 4;
    localparam int ENC_4X  = 3;
    localparam int ENC_3X  = 2;
    localparam int ENC_2X  = 1;
    localparam int ENC_1X  = 0;

    // Each radix-8 digit consumes three multiplier bits, so an n-bit operand
    // needs ceil(n/3) digits once it is sign-extended to a multiple of three.
    function automatic int ndig(int n);
        return (n + 2) / 3;
    endfunction

endpackage

// File: rtl/booth_r8_seq_mult_if.sv
// -----------------------------------------------------------------------------
// booth_r8_seq_mult_if
// Operand/result handshake bundle for booth_r8_seq_mult.
//   in_valid/in_ready  : operand handshake (x, y signed, N bits)
//   out_valid/out_ready: result handshake (p signed, 2N bits)
// Modports:
//   master : the producer/consumer side (drives operands, accepts product)
//   slave  : the multiplier core
// -----------------------------------------------------------------------------
interface booth_r8_seq_mult_if #(
    parameter int N = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     x;
    logic [N-1:0]     y;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   p;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/booth_r8_seq_mult_b_encoder.sv
// -----------------------------------------------------------------------------
// b_encoder
// Radix-8 Booth digit encoder. The 4-bit window {y[3i+2:3i], y[3i-1]} has
// value -4*w[3] + 2*w[2] + w[1] + w[0], in the range -4..+4.
// Ports:
//   win [3:0] : Booth window, MSB first, LSB is the overlap bit
//   enc [4:0] : bit4 negate, bits3:0 one-hot select 4X/3X/2X/1X, all zero = 0
// -----------------------------------------------------------------------------
module b_encoder
    import booth_pkg::*;
(
    input  logic [3:0] win,
    output logic [4:0] enc
);

    // Plain lookup of the window value; negative digits set the negate bit
    // and select the matching magnitude. 0000 and 1111 both encode zero.
    always_comb begin
        enc = '0;
        case (win)
            4'b0001, 4'b0010: enc[ENC_1X] = 1'b1;
            4'b0011, 4'b0100: enc[ENC_2X] = 1'b1;
            4'b0101, 4'b0110: enc[ENC_3X] = 1'b1;
            4'b0111:          enc[ENC_4X] = 1'b1;
            4'b1000: begin
                enc[ENC_NEG] = 1'b1;
                enc[ENC_4X]  = 1'b1;
            end
            4'b1001, 4'b1010: begin
                enc[ENC_NEG] = 1'b1;
                enc[ENC_3X]  = 1'b1;
            end
            4'b1011, 4'b1100: begin
                enc[ENC_NEG] = 1'b1;
                enc[ENC_2X]  = 1'b1;
            end
            4'b1101, 4'b1110: begin
                enc[ENC_NEG] = 1'b1;
                enc[ENC_1X]  = 1'b1;
            end
            default: enc = '0;
        endcase
    end

endmodule

// File: rtl/booth_r8_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_r8_seq_mult
// Sequential signed radix-8 Booth multiplier, one Booth digit per cycle.
// Flow: IDLE (accept) -> PRECOMP (3X = X + 2X) -> ACCUM (NDIG digits) -> DONE.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : booth_r8_seq_mult_if.slave (in_valid/in_ready/x/y,
//           out_valid/out_ready/p)
// -----------------------------------------------------------------------------
module booth_r8_seq_mult
    import booth_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_r8_seq_mult_if.slave   bus
);

    localparam int NDIG = ndig(N);
    localparam int YW   = 3 * NDIG;
    localparam int PW   = 2 * N;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    mult_state_t   state, nxt_state;

    logic [PW-1:0] xs;
    logic [PW-1:0] x3s;
    logic [PW-1:0] acc;
    logic [PW-1:0] p_q;
    logic [YW-1:0] ysh;
    logic          yprev;
    logic [CW-1:0] cnt;

    logic [3:0]    win;
    logic [4:0]    enc;
    logic [3:0]    sel;
    logic          sel_legal;
    logic [PW-1:0] mag;
    logic [PW-1:0] term;
    logic [PW-1:0] add_a;
    logic [PW-1:0] add_b;
    logic [PW-1:0] sum;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.p         = p_q;

    // The low three bits of the shifting Y register plus the bit shifted out
    // last time form the current window; yprev starts at 0 for digit 0.
    assign win = {ysh[2:0], yprev};

    b_encoder u_enc (
        .win (win),
        .enc (enc)
    );

    // An encoding is usable only with at most one select bit and no negate on
    // a zero select; anything else contributes nothing to the product.
    assign sel       = enc[3:0];
    assign sel_legal = $onehot0(sel) && !(enc[ENC_NEG] && (sel == 4'b0000));

    // Pick the magnitude from the pre-aligned multiplicand registers. 2X and
    // 4X are plain shifts of X; 3X comes from the PRECOMP result.
    always_comb begin
        mag = '0;
        if (sel_legal) begin
            case (sel)
                4'b0001: mag = xs;
                4'b0010: mag = xs << 1;
                4'b0100: mag = x3s;
                4'b1000: mag = xs << 2;
                default: mag = '0;
            endcase
        end
        term = (sel_legal && enc[ENC_NEG]) ? (~mag + PW'(1)) : mag;
    end

    // The single 2N-bit adder: builds X + 2X during PRECOMP, and accumulates
    // the current digit term for the rest of the operation.
    always_comb begin
        add_a = acc;
        add_b = term;
        if (state == PRECOMP) begin
            add_a = xs;
            add_b = xs << 1;
        end
        sum = add_a + add_b;
    end

    // State register only; all decisions live in the next-state block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state logic. Operands are taken only in IDLE, so in_valid while
    // busy has no effect, and DONE waits for the consumer before freeing up.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (bus.in_valid) nxt_state = PRECOMP;
            PRECOMP: nxt_state = ACCUM;
            ACCUM:   if (cnt == LAST_DIG) nxt_state = DONE;
            DONE:    if (bus.out_ready) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Datapath registers. Each ACCUM cycle the multiplicand copies shift left
    // by three to track the digit weight, while Y shifts right by three so
    // the next window is always at the bottom. p is written only when the
    // last digit lands, so the consumer never sees a partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs    <= '0;
            x3s   <= '0;
            acc   <= '0;
            p_q   <= '0;
            ysh   <= '0;
            yprev <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xs    <= PW'($signed(bus.x));
                        ysh   <= YW'($signed(bus.y));
                        yprev <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                PRECOMP: begin
                    x3s <= sum;
                end
                ACCUM: begin
                    acc   <= sum;
                    xs    <= xs << 3;
                    x3s   <= x3s << 3;
                    ysh   <= {{3{ysh[YW-1]}}, ysh[YW-1:3]};
                    yprev <= ysh[2];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_DIG) begin
                        p_q <= sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The encoder should never emit a multi-select or a negated zero.
    enc_legal_a: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == ACCUM) |-> sel_legal
    );

endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_r8_seq_mult
// Self-checking bench for booth_r8_seq_mult (N=16). A table of operand pairs
// with constant expected products, hand sequences for latency, output stall
// and mid-operation reset, then random traffic with random handshake gaps.
// Expected products go into a queue at acceptance; a monitor pops and
// compares them as each product is delivered.
// -----------------------------------------------------------------------------
module tb_booth_r8_seq_mult;
    import booth_pkg::*;

    localparam int N    = 16;
    localparam int PW   = 2 * N;
    localparam int NRND = 2000;

    typedef struct {
        logic [N-1:0]  x;
        logic [N-1:0]  y;
        logic [PW-1:0] exp_p;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    booth_r8_seq_mult_if #(.N(N)) bus ();

    booth_r8_seq_mult #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int            checks     = 0;
    int            errors     = 0;
    int            cyc        = 0;
    int            rise_cyc   = -1;
    bit            rand_ready = 1'b0;
    logic          prev_ov    = 1'b0;
    logic [PW-1:0] sb_q[$];
    vec_t          vecs[12];

    // Free-running edge counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Independent golden product, sign-extended before multiplying.
    function automatic logic [PW-1:0] golden(input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Monitor: on the falling edge, a delivered product is compared with the
    // oldest pending expectation; also notes when out_valid rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got p=0x%0h, required no delivery", bus.p);
                end else begin
                    checkOutput("product", bus.p, sb_q.pop_front());
                end
            end
        end
    end

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present one operand pair and hold it until the core accepts it.
    task automatic applyStimulus(input logic [N-1:0] xv, input logic [N-1:0] yv,
                                 input logic [PW-1:0] expv, output int acc_cyc);
        bit done;
        done        = 1'b0;
        acc_cyc     = -1;
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        for (int i = 0; i < 300 && !done; i++) begin
            if (bus.in_ready) begin
                sb_q.push_back(expv);
                acc_cyc = cyc;
                done    = 1'b1;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 300 cycles, required 1");
        end
    endtask

    task automatic waitRise(input int budget);
        for (int i = 0; i < budget && rise_cyc < 0; i++) tick();
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
        checkOutput("drain_pending", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            acc;
        logic [N-1:0]  rx;
        logic [N-1:0]  ry;
        logic [PW-1:0] hold_p;

        vecs[0]  = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1]  = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[2]  = '{16'hFFF9, 16'h7FFF, 32'hFFFC8007};
        vecs[3]  = '{16'd12345, 16'h8421, 32'hE8AA9B59};
        vecs[4]  = '{16'd12345, 16'h7BDE, 32'h1755346E};
        vecs[5]  = '{16'd12345, 16'hFFFF, 32'hFFFFCFC7};
        vecs[6]  = '{16'd12345, 16'h0000, 32'h00000000};
        vecs[7]  = '{16'h0000, 16'hFFFF, 32'h00000000};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[9]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[10] = '{16'h8000, 16'h7FFF, 32'hC0008000};
        vecs[11] = '{16'h0001, 16'h8000, 32'hFFFF8000};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_p", 64'(bus.p), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] latency check");
        rise_cyc = -1;
        applyStimulus(16'd3, 16'd5, 32'h0000000F, acc);
        waitRise(30);
        checkOutput("latency", 64'(rise_cyc - acc), 64'd8);
        waitDrain(30);

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].exp_p, acc);
        end
        waitDrain(30);

        $display("[TB] output stall");
        bus.out_ready = 1'b0;
        rise_cyc      = -1;
        applyStimulus(16'hFF9C, 16'd77, 32'hFFFFE1EC, acc);
        waitRise(30);
        checkOutput("stall_reached_done", 64'(bus.out_valid), 64'd1);
        hold_p       = 32'hFFFFE1EC;
        bus.in_valid = 1'b1;
        bus.x        = 16'd5;
        bus.y        = 16'd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("stall_p", 64'(bus.p), 64'(hold_p));
        end
        bus.out_ready = 1'b1;
        applyStimulus(16'd5, 16'd6, 32'h0000001E, acc);
        waitDrain(30);

        $display("[TB] reset during accumulate");
        applyStimulus(16'd100, 16'd200, 32'h00004E20, acc);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("abort_p", 64'(bus.p), 64'd0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        rise_cyc = -1;
        applyStimulus(16'd0, 16'hFFFF, 32'h00000000, acc);
        waitRise(30);
        checkOutput("post_reset_latency", 64'(rise_cyc - acc), 64'd8);
        waitDrain(30);

        $display("[TB] random traffic");
        rand_ready = 1'b1;
        for (int i = 0; i < NRND; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            rx = N'($urandom());
            ry = N'($urandom());
            if ($urandom_range(0, 15) == 0) rx = 16'h8000;
            if ($urandom_range(0, 15) == 0) ry = 16'h8000;
            applyStimulus(rx, ry, golden(rx, ry), acc);
        end
        waitDrain(300);
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
